// File: rtl/pipe_pkg.sv
// Shared constants for the processor's inter-stage pipeline registers.
// Stage tops pack and unpack their control/datapath bundles with the field
// offsets below before handing them to pipe_stage_skid.
//   - EXMEM_CTRL_W / EXMEM_DATA_W : bundle widths of the EX/MEM register
//   - CTRL_* / DATA_*             : LSB offsets of each field in the bundles
//   - br_op_e, load_sel_e, store_sel_e : encodings carried in the bundles
package pipe_pkg;

    localparam int EXMEM_CTRL_W = 8;
    localparam int EXMEM_DATA_W = 101;

    // Control bundle bit offsets (all-zero bundle == bubble)
    localparam int CTRL_REG_WR     = 0;
    localparam int CTRL_MEM_RD     = 1;
    localparam int CTRL_MEM_WR     = 2;
    localparam int CTRL_BRANCH     = 3;
    localparam int CTRL_MEM_TO_REG = 4;
    localparam int CTRL_BR_OP_LO   = 5;   // 2 bits
    localparam int CTRL_ALU_SRC    = 7;

    // Datapath bundle offsets: rd[4:0], pc[36:5], readdata2[68:37], alu_result[100:69]
    localparam int DATA_RD_LO  = 0;
    localparam int DATA_PC_LO  = 5;
    localparam int DATA_RD2_LO = 37;
    localparam int DATA_ALU_LO = 69;

    typedef enum logic [1:0] {
        BR_NONE = 2'd0,
        BR_EQ   = 2'd1,
        BR_NE   = 2'd2,
        BR_JMP  = 2'd3
    } br_op_e;

    typedef enum logic [1:0] {
        LD_W  = 2'd0,
        LD_H  = 2'd1,
        LD_B  = 2'd2,
        LD_BU = 2'd3
    } load_sel_e;

    typedef enum logic [1:0] {
        ST_W = 2'd0,
        ST_H = 2'd1,
        ST_B = 2'd2
    } store_sel_e;

    // Number of entries held, from the two slot valid bits.
    function automatic logic [1:0] occ_count(input logic head_v, input logic skid_v);
        return {1'b0, head_v} + {1'b0, skid_v};
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry: valid flag, control bundle and datapath bundle.
// State changes on the falling clock edge, like the rest of the pipeline regs.
//   clk, rst      : clock (falling edge) and synchronous active-high reset
//   load          : capture d_ctrl/d_data and set valid (wins over clear)
//   clear         : drop the entry; control zeroed, datapath held
//   d_ctrl/d_data : entry to capture
//   valid/ctrl/data : registered entry
module pipe_slot #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 101
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [CTRL_W-1:0] d_ctrl,
    input  logic [DATA_W-1:0] d_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    logic              valid_reg;
    logic [CTRL_W-1:0] ctrl_reg;
    logic [DATA_W-1:0] data_reg;

    always_ff @(negedge clk) begin
        if (rst) begin
            valid_reg <= 1'b0;
            ctrl_reg  <= '0;
            data_reg  <= '0;
        end else if (load) begin
            valid_reg <= 1'b1;
            ctrl_reg  <= d_ctrl;
            data_reg  <= d_data;
        end else if (clear) begin
            // Bubble: control goes to zero together with valid, data is kept.
            valid_reg <= 1'b0;
            ctrl_reg  <= '0;
        end
    end

    assign valid = valid_reg;
    assign ctrl  = ctrl_reg;
    assign data  = data_reg;

endmodule

// File: rtl/pipe_stage_skid.sv
// Parametrised inter-stage pipeline register with valid/ready handshake,
// flush, and an optional 2-entry skid buffer (SKID=1) that keeps in_ready
// free of any combinational path from out_ready.
//   clk, rst              : clock (state on falling edge), sync active-high reset
//   flush                 : kill held entries and the entry offered this cycle
//   in_valid/in_ready     : producer handshake; in_ctrl/in_data entry offered
//   out_valid/out_ready   : consumer handshake; out_ctrl/out_data head entry
//   occupancy             : entries held (0..2)
//   stall_cnt             : consecutive cycles with out_valid & ~out_ready, saturating
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int CTRL_W = EXMEM_CTRL_W,
    parameter int DATA_W = EXMEM_DATA_W,
    parameter bit SKID   = 1'b1,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              head_valid;
    logic              head_load;
    logic              head_clear;
    logic [CTRL_W-1:0] head_ctrl;
    logic [DATA_W-1:0] head_data;
    logic [CTRL_W-1:0] head_d_ctrl;
    logic [DATA_W-1:0] head_d_data;
    logic              skid_valid;
    logic              accept;
    logic              rel;
    logic [CNT_W-1:0]  stall_reg;
    logic [CNT_W-1:0]  stall_next;

    // in_ready already carries ~rst, so nothing is accepted during reset.
    assign accept = in_valid & in_ready;
    assign rel    = head_valid & out_ready;

    // Load has priority inside the slot, so a release that is refilled the
    // same edge keeps the head valid. head_load is gated by flush elsewhere.
    assign head_clear = flush | rel;

    pipe_slot #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
    ) u_head (
        .clk    (clk),
        .rst    (rst),
        .load   (head_load),
        .clear  (head_clear),
        .d_ctrl (head_d_ctrl),
        .d_data (head_d_data),
        .valid  (head_valid),
        .ctrl   (head_ctrl),
        .data   (head_data)
    );

    if (SKID) begin : g_skid
        logic              skid_load;
        logic              skid_clear;
        logic [CTRL_W-1:0] skid_ctrl;
        logic [DATA_W-1:0] skid_data;

        // Skid empty guarantees room for one more entry whatever the consumer does.
        assign in_ready = ~rst & ~skid_valid;

        always_comb begin
            head_load   = 1'b0;
            skid_load   = 1'b0;
            head_d_ctrl = in_ctrl;
            head_d_data = in_data;
            if (!flush) begin
                if (skid_valid) begin
                    // in_ready is low, so only skid -> head movement is possible.
                    if (rel) begin
                        head_load   = 1'b1;
                        head_d_ctrl = skid_ctrl;
                        head_d_data = skid_data;
                    end
                end else if (accept) begin
                    if (!head_valid || rel) begin
                        head_load = 1'b1;
                    end else begin
                        skid_load = 1'b1;
                    end
                end
            end
        end

        assign skid_clear = flush | (rel & skid_valid);

        pipe_slot #(
            .CTRL_W (CTRL_W),
            .DATA_W (DATA_W)
        ) u_skid (
            .clk    (clk),
            .rst    (rst),
            .load   (skid_load),
            .clear  (skid_clear),
            .d_ctrl (in_ctrl),
            .d_data (in_data),
            .valid  (skid_valid),
            .ctrl   (skid_ctrl),
            .data   (skid_data)
        );
    end else begin : g_single
        assign in_ready    = ~rst & (out_ready | ~head_valid);
        assign head_load   = ~flush & accept;
        assign head_d_ctrl = in_ctrl;
        assign head_d_data = in_data;
        assign skid_valid  = 1'b0;
    end

    // Stall counter: restarts whenever the head is not stuck this cycle.
    always_comb begin
        stall_next = '0;
        if (!flush && head_valid && !out_ready) begin
            if (stall_reg == {CNT_W{1'b1}}) begin
                stall_next = stall_reg;
            end else begin
                stall_next = stall_reg + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            stall_reg <= '0;
        end else begin
            stall_reg <= stall_next;
        end
    end

    assign out_valid = head_valid;
    assign out_ctrl  = head_ctrl;
    assign out_data  = head_data;
    assign occupancy = occ_count(head_valid, skid_valid);
    assign stall_cnt = stall_reg;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and random checks of pipe_stage_skid in three builds sharing one
// stimulus: a = SKID=1/CNT_W=8, b = SKID=0/CNT_W=8, c = SKID=1/CNT_W=2.
// Inputs change at posedge+1; the DUT updates on negedge; outputs are read
// at the following posedge+1.
module tb_pipe_stage_skid;

    localparam int CW = 8;
    localparam int DW = 101;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          out_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;

    logic          a_in_ready, b_in_ready, c_in_ready;
    logic          a_out_valid, b_out_valid, c_out_valid;
    logic [CW-1:0] a_out_ctrl, b_out_ctrl, c_out_ctrl;
    logic [DW-1:0] a_out_data, b_out_data, c_out_data;
    logic [1:0]    a_occ, b_occ, c_occ;
    logic [7:0]    a_stall, b_stall;
    logic [1:0]    c_stall;

    pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b1), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_ctrl(a_out_ctrl), .out_data(a_out_data), .occupancy(a_occ), .stall_cnt(a_stall)
    );

    pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b0), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_ctrl(b_out_ctrl), .out_data(b_out_data), .occupancy(b_occ), .stall_cnt(b_stall)
    );

    pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b1), .CNT_W(2)) dut_c (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(c_in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(c_out_valid), .out_ready(out_ready),
        .out_ctrl(c_out_ctrl), .out_data(c_out_data), .occupancy(c_occ), .stall_cnt(c_stall)
    );

    int n_chk   = 0;
    int n_err   = 0;
    bit verbose = 1'b1;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else if (verbose) begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [CW-1:0] ctrl_of(input logic [DW-1:0] d);
        return {1'b1, d[6:0]};
    endfunction

    task automatic offer(input logic v, input logic [DW-1:0] d);
        in_valid = v;
        in_data  = d;
        in_ctrl  = ctrl_of(d);
    endtask

    // Per-build views for the random phase.
    typedef logic [CW+DW-1:0] ent_t;
    ent_t          sb [3][$];
    logic          ir_v  [3];
    logic          ov_v  [3];
    logic [CW-1:0] oc_v  [3];
    logic [DW-1:0] od_v  [3];
    logic [1:0]    occ_v [3];
    logic [7:0]    st_v  [3];

    always_comb begin
        ir_v[0] = a_in_ready;  ir_v[1] = b_in_ready;  ir_v[2] = c_in_ready;
        ov_v[0] = a_out_valid; ov_v[1] = b_out_valid; ov_v[2] = c_out_valid;
        oc_v[0] = a_out_ctrl;  oc_v[1] = b_out_ctrl;  oc_v[2] = c_out_ctrl;
        od_v[0] = a_out_data;  od_v[1] = b_out_data;  od_v[2] = c_out_data;
        occ_v[0] = a_occ;      occ_v[1] = b_occ;      occ_v[2] = c_occ;
        st_v[0] = a_stall;     st_v[1] = b_stall;     st_v[2] = {6'b0, c_stall};
    end

    initial begin
        int           sc_m [3];
        int           sc_max [3];
        bit           has_skid [3];
        logic [127:0] r;
        logic         exp_ir;
        ent_t         head;

        sc_max   = '{255, 255, 3};
        has_skid = '{1'b1, 1'b0, 1'b1};

        // ---------------- reset with in_valid held high ----------------
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        offer(1'b1, 101'h77);
        step;
        chk("rst_a_in_ready_comb", a_in_ready, 0);
        chk("rst_b_in_ready_comb", b_in_ready, 0);
        step;
        step;
        chk("rst_a_out_valid", a_out_valid, 0);
        chk("rst_a_out_ctrl", a_out_ctrl, 0);
        chk("rst_a_out_data", a_out_data, 0);
        chk("rst_a_occ", a_occ, 0);
        chk("rst_a_stall", a_stall, 0);
        chk("rst_a_in_ready", a_in_ready, 0);
        chk("rst_b_out_valid", b_out_valid, 0);
        chk("rst_b_in_ready", b_in_ready, 0);

        // ---------------- streaming 1..8, latency 1 ----------------
        rst = 1'b0; out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            offer(1'b1, DW'(i));
            step;
            chk($sformatf("stream_a_valid_%0d", i), a_out_valid, 1);
            chk($sformatf("stream_a_data_%0d", i), a_out_data, i);
            chk($sformatf("stream_a_ctrl_%0d", i), a_out_ctrl, ctrl_of(DW'(i)));
            chk($sformatf("stream_b_data_%0d", i), b_out_data, i);
            chk($sformatf("stream_a_occ_%0d", i), a_occ, 1);
        end
        offer(1'b0, '0);
        step;
        chk("stream_end_a_valid", a_out_valid, 0);
        chk("stream_end_a_ctrl", a_out_ctrl, 0);
        chk("stream_end_a_occ", a_occ, 0);
        chk("stream_end_a_in_ready", a_in_ready, 1);

        // ---------------- backpressure into the skid ----------------
        offer(1'b1, 101'd5);
        step;
        chk("bp_a_head5", a_out_data, 5);
        out_ready = 1'b0;
        offer(1'b1, 101'd6);
        #1;
        chk("bp_b_in_ready_same_cycle", b_in_ready, 0);
        chk("bp_a_in_ready_before", a_in_ready, 1);
        step;
        offer(1'b0, '0);
        chk("bp_a_occ2", a_occ, 2);
        chk("bp_a_in_ready_low", a_in_ready, 0);
        chk("bp_a_head_still5", a_out_data, 5);
        chk("bp_a_stall1", a_stall, 1);
        chk("bp_b_occ1", b_occ, 1);
        step;
        chk("bp_a_stall2", a_stall, 2);
        step;
        chk("bp_a_stall3", a_stall, 3);
        out_ready = 1'b1;
        step;
        chk("bp_a_head6", a_out_data, 6);
        chk("bp_a_ctrl6", a_out_ctrl, ctrl_of(101'd6));
        chk("bp_a_valid6", a_out_valid, 1);
        chk("bp_a_in_ready_back", a_in_ready, 1);
        chk("bp_a_stall0", a_stall, 0);
        chk("bp_a_occ1", a_occ, 1);
        step;
        chk("bp_a_drained", a_out_valid, 0);
        chk("bp_a_occ0", a_occ, 0);

        // ---------------- stall counter saturation (CNT_W=2) ----------------
        offer(1'b1, 101'hA);
        step;
        offer(1'b0, '0);
        out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            step;
            chk($sformatf("sat_c_stall_%0d", i), c_stall, (i > 3) ? 3 : i);
            chk($sformatf("sat_a_stall_%0d", i), a_stall, i);
        end

        // ---------------- flush with both entries held ----------------
        offer(1'b1, 101'hB);
        step;
        chk("fl_a_occ2", a_occ, 2);
        flush = 1'b1;
        offer(1'b1, 101'd9);
        step;
        chk("fl_a_valid", a_out_valid, 0);
        chk("fl_a_ctrl", a_out_ctrl, 0);
        chk("fl_a_occ", a_occ, 0);
        chk("fl_a_stall", a_stall, 0);
        chk("fl_a_data_held", a_out_data, 101'hA);
        chk("fl_b_valid", b_out_valid, 0);
        flush = 1'b0;
        offer(1'b0, '0);
        out_ready = 1'b1;
        step;
        chk("fl_a_stays_empty", a_out_valid, 0);

        // ---------------- flush while the stage can accept ----------------
        flush = 1'b1;
        offer(1'b1, 101'd9);
        #1;
        chk("fl2_a_in_ready", a_in_ready, 1);
        step;
        chk("fl2_a_valid", a_out_valid, 0);
        chk("fl2_a_occ", a_occ, 0);
        chk("fl2_a_data_not9", a_out_data, 101'hA);
        chk("fl2_b_valid", b_out_valid, 0);
        flush = 1'b0;
        offer(1'b0, '0);
        step;
        chk("fl2_a_valid_after", a_out_valid, 0);

        // ---------------- reset mid-transfer ----------------
        out_ready = 1'b0;
        offer(1'b1, 101'hC);
        step;
        offer(1'b1, 101'hD);
        step;
        chk("mrst_a_occ2", a_occ, 2);
        rst = 1'b1;
        offer(1'b0, '0);
        step;
        chk("mrst_a_valid", a_out_valid, 0);
        chk("mrst_a_occ", a_occ, 0);
        chk("mrst_a_data", a_out_data, 0);
        chk("mrst_a_stall", a_stall, 0);
        rst = 1'b0;
        out_ready = 1'b1;
        step;
        chk("mrst_a_nothing_survives", a_out_valid, 0);
        chk("mrst_a_in_ready", a_in_ready, 1);

        // ---------------- random valid/ready vs scoreboard ----------------
        verbose = 1'b0;
        for (int d = 0; d < 3; d++) sc_m[d] = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            r = {$urandom, $urandom, $urandom, $urandom};
            in_valid  = ($urandom_range(0, 9) < 6);
            out_ready = ($urandom_range(0, 9) < 6);
            in_data   = r[DW-1:0];
            in_ctrl   = CW'($urandom);
            #1;
            for (int d = 0; d < 3; d++) begin
                exp_ir = has_skid[d] ? (sb[d].size() < 2)
                                     : (out_ready || sb[d].size() == 0);
                chk($sformatf("rnd%0d_in_ready", d), ir_v[d], exp_ir);
                chk($sformatf("rnd%0d_occ", d), occ_v[d], sb[d].size());
                chk($sformatf("rnd%0d_valid", d), ov_v[d], sb[d].size() != 0);
                chk($sformatf("rnd%0d_stall", d), st_v[d], sc_m[d]);
                if (sb[d].size() == 0) begin
                    chk($sformatf("rnd%0d_bubble_ctrl", d), oc_v[d], 0);
                end else begin
                    head = sb[d][0];
                    chk($sformatf("rnd%0d_head", d), {oc_v[d], od_v[d]}, head);
                    if (out_ready) void'(sb[d].pop_front());
                end
                if (in_valid && exp_ir) sb[d].push_back({in_ctrl, in_data});
                if (ov_v[d] && !out_ready) begin
                    sc_m[d] = (sc_m[d] == sc_max[d]) ? sc_m[d] : sc_m[d] + 1;
                end else begin
                    sc_m[d] = 0;
                end
            end
            step;
        end
        verbose = 1'b1;
        $display("random phase done after 10000 cycles");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
